// File: rtl/core_logic_gen.sv
// JTAG core-logic pattern source: FIB/COUNT/LFSR/CONST generator with a DR snapshot and a sticky wrap flag.
// Latency: 1 TCK edge for advance, reseed and capture. No backpressure: the TAP controller strobes drive it directly.
module core_logic_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_TAPS = WIDTH'('hB8),
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'('hDD)
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             SHIFTDR,
  input  logic             CAPTUREDR,
  input  logic             UPDATEDR,
  input  logic [WIDTH-1:0] UPDATE_DATA,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] CORE_LOGIC_DATA,
  output logic             WRAP
);

  typedef enum logic [1:0] {
    MODE_FIB   = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_CONST = 2'b11
  } mode_e;

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH:0]   fib_sum;

  always_comb begin
    cur_d   = cur_q;
    prev_d  = prev_q;
    snap_d  = snap_q;
    wrap_d  = wrap_q;
    fib_sum = {1'b0, cur_q} + {1'b0, prev_q};

    // Capture always samples the pre-edge current, whatever else happens this edge.
    if (CAPTUREDR) begin
      snap_d = (mode_e'(MODE) == MODE_CONST) ? CONST_VAL : cur_q;
    end

    if (UPDATEDR) begin
      cur_d  = UPDATE_DATA;
      prev_d = '0;
      wrap_d = 1'b0;
    end else if (!SHIFTDR) begin
      case (mode_e'(MODE))
        MODE_FIB: begin
          cur_d  = fib_sum[WIDTH-1:0];
          prev_d = cur_q;
          wrap_d = wrap_q | fib_sum[WIDTH];
        end
        MODE_COUNT: begin
          cur_d  = cur_q + WIDTH'(1);
          wrap_d = wrap_q | (&cur_q);
        end
        MODE_LFSR: begin
          // An all-zero Galois register never leaves zero, so kick it back to 1.
          if (cur_q == '0) begin
            cur_d = WIDTH'(1);
          end else begin
            cur_d = (cur_q >> 1) ^ (cur_q[0] ? LFSR_TAPS : '0);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge TCK) begin
    if (TRST) begin
      cur_q  <= WIDTH'(1);
      prev_q <= '0;
      snap_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cur_q  <= cur_d;
      prev_q <= prev_d;
      snap_q <= snap_d;
      wrap_q <= wrap_d;
    end
  end

  assign CORE_LOGIC_DATA = snap_q;
  assign WRAP            = wrap_q;

endmodule

// File: tb/tb_core_logic_gen.sv
// Bench for core_logic_gen: directed TAP sequences plus random traffic, scored against an arithmetic model.
// Expected snapshots are queued at stimulus time and popped by an independent output monitor.
module tb_core_logic_gen;

  localparam logic [1:0] FIB   = 2'b00;
  localparam logic [1:0] COUNT = 2'b01;
  localparam logic [1:0] LFSR  = 2'b10;
  localparam logic [1:0] CONST = 2'b11;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       SHIFTDR = 1'b0;
  logic       CAPTUREDR = 1'b0;
  logic       UPDATEDR = 1'b0;
  logic [7:0] UPDATE_DATA = 8'h00;
  logic [1:0] MODE = 2'b00;
  logic [7:0] CORE_LOGIC_DATA;
  logic       WRAP;

  core_logic_gen #(.WIDTH(8), .LFSR_TAPS(8'hB8), .CONST_VAL(8'hDD)) dut (
    .TCK(TCK),
    .TRST(TRST),
    .SHIFTDR(SHIFTDR),
    .CAPTUREDR(CAPTUREDR),
    .UPDATEDR(UPDATEDR),
    .UPDATE_DATA(UPDATE_DATA),
    .MODE(MODE),
    .CORE_LOGIC_DATA(CORE_LOGIC_DATA),
    .WRAP(WRAP)
  );

  always #5 TCK = ~TCK;

  typedef struct {
    logic [7:0] data;
    logic       wrap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: generator state as plain numbers.
  logic [7:0] m_cur = 8'h01;
  logic [7:0] m_prev = 8'h00;
  logic [7:0] m_snap = 8'h00;
  logic       m_wrap = 1'b0;

  task automatic step(input logic trst, input logic shift, input logic cap, input logic upd,
                      input logic [7:0] ud, input logic [1:0] md);
    logic [7:0] old_cur;
    int         s;
    exp_t       e;
    @(negedge TCK);
    TRST = trst; SHIFTDR = shift; CAPTUREDR = cap; UPDATEDR = upd;
    UPDATE_DATA = ud; MODE = md;
    old_cur = m_cur;
    if (trst) begin
      m_cur = 8'h01; m_prev = 8'h00; m_snap = 8'h00; m_wrap = 1'b0;
    end else begin
      if (cap) m_snap = (md == CONST) ? 8'hDD : old_cur;
      if (upd) begin
        m_cur = ud; m_prev = 8'h00; m_wrap = 1'b0;
      end else if (!shift) begin
        case (md)
          FIB: begin
            s = int'(m_cur) + int'(m_prev);
            m_prev = m_cur;
            m_cur  = 8'(s % 256);
            if (s >= 256) m_wrap = 1'b1;
          end
          COUNT: begin
            s = int'(m_cur) + 1;
            if (s >= 256) m_wrap = 1'b1;
            m_cur = 8'(s % 256);
          end
          LFSR: begin
            if (m_cur == 8'h00) m_cur = 8'h01;
            else m_cur = (m_cur >> 1) ^ (m_cur[0] ? 8'hB8 : 8'h00);
          end
          default: ;
        endcase
      end
    end
    if (trst || cap) begin
      e.data = m_snap;
      e.wrap = m_wrap;
      sb_q.push_back(e);
    end
    @(posedge TCK);
  endtask

  task automatic adv(input logic [1:0] md);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, md);
  endtask

  task automatic cap_hold(input logic [1:0] md);
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, md);
  endtask

  task automatic reseed(input logic [7:0] v, input logic [1:0] md);
    step(1'b0, 1'b0, 1'b0, 1'b1, v, md);
  endtask

  // Output monitor: a snapshot is presented after any capture or reset edge.
  logic       out_evt = 1'b0;
  logic       have_last = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         n_pop = 0;

  always @(posedge TCK) out_evt <= CAPTUREDR | TRST;

  always @(negedge TCK) begin
    exp_t e;
    if (out_evt) begin
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_underflow: output event with no expected entry, data=%h", CORE_LOGIC_DATA);
      end else begin
        e = sb_q.pop_front();
        n_pop++;
        checks++;
        if (CORE_LOGIC_DATA !== e.data) begin
          failures++;
          $display("FAIL snap_data #%0d: got %h expected %h", n_pop, CORE_LOGIC_DATA, e.data);
        end
        checks++;
        if (WRAP !== e.wrap) begin
          failures++;
          $display("FAIL snap_wrap #%0d: got %b expected %b", n_pop, WRAP, e.wrap);
        end
        last_data = e.data;
        have_last = 1'b1;
      end
    end else if (have_last) begin
      checks++;
      if (CORE_LOGIC_DATA !== last_data) begin
        failures++;
        $display("FAIL snap_stable: got %h expected held %h", CORE_LOGIC_DATA, last_data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then the Fibonacci walk to 233 and its first carry.
    step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, FIB);
    repeat (12) adv(FIB);
    cap_hold(FIB);
    adv(FIB);
    cap_hold(FIB);

    // Counter wrap through all-ones, then reseed clears WRAP.
    reseed(8'hFE, COUNT);
    repeat (2) adv(COUNT);
    cap_hold(COUNT);
    reseed(8'h10, COUNT);
    cap_hold(COUNT);

    // LFSR from 1: three steps, full period, and lock-up escape.
    reseed(8'h01, LFSR);
    repeat (3) begin
      adv(LFSR);
      cap_hold(LFSR);
    end
    repeat (252) adv(LFSR);
    cap_hold(LFSR);
    reseed(8'h00, LFSR);
    cap_hold(LFSR);
    adv(LFSR);
    cap_hold(LFSR);

    // CONST capture and generator hold across 10 edges.
    cap_hold(CONST);
    repeat (10) adv(CONST);
    cap_hold(COUNT);

    // Capture, 8-cycle shift freeze, then capture coinciding with reseed.
    reseed(8'h03, FIB);
    repeat (3) adv(FIB);
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, FIB);
    repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, FIB);
    cap_hold(FIB);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h5A, FIB);
    cap_hold(FIB);

    // Reset mid-shift with WRAP set, all strobes active.
    reseed(8'hFF, COUNT);
    adv(COUNT);
    cap_hold(COUNT);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, COUNT);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'hAA, COUNT);
    cap_hold(FIB);
    repeat (2) adv(FIB);
    cap_hold(FIB);

    // Random TAP traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
           8'($urandom), 2'($urandom));
    end

    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, FIB);
    @(negedge TCK);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expected snapshots never presented, required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
